// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared states and constants for the audio record/play controller
package audio_pkg;

    localparam int ADDR_W = 18;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam int DEF_FRAMES_PER_SEC = 32000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        DONE   = 2'd3
    } aud_state_e;

endpackage

// File: rtl/audio_rec_play_ctrl_if.sv
// rtl/audio_rec_play_ctrl_if.sv - key, frame clock and codec control bundle
interface audio_rec_play_ctrl_if #(
    parameter int ADDR_W = audio_pkg::ADDR_W,
    parameter int SEC_W  = 8
);
    logic              key_record;
    logic              key_play;
    logic              key_stop;
    logic              speed_fast;
    logic [3:0]        speed_rate;
    logic              interp_en;
    logic              AUD_ADCLRCK;
    logic              AUD_DACLRCK;
    logic [ADDR_W-1:0] codec_addr;

    logic              stop;
    logic              record;
    logic              fast;
    logic [3:0]        rate;
    logic              interp;
    logic [1:0]        state;
    logic [ADDR_W-1:0] rec_end_addr;
    logic              play_done;
    logic [SEC_W-1:0]  elapsed_sec;

    modport master (
        output key_record, key_play, key_stop, speed_fast, speed_rate, interp_en,
               AUD_ADCLRCK, AUD_DACLRCK, codec_addr,
        input  stop, record, fast, rate, interp, state, rec_end_addr, play_done, elapsed_sec
    );

    modport slave (
        input  key_record, key_play, key_stop, speed_fast, speed_rate, interp_en,
               AUD_ADCLRCK, AUD_DACLRCK, codec_addr,
        output stop, record, fast, rate, interp, state, rec_end_addr, play_done, elapsed_sec
    );

endinterface

// File: rtl/lrck_sec_counter.sv
// rtl/lrck_sec_counter.sv - LRCK rising-edge frame counter feeding a saturating seconds counter
module lrck_sec_counter #(
    parameter int FRAMES_PER_SEC = audio_pkg::DEF_FRAMES_PER_SEC,
    parameter int SEC_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             lrck,
    output logic [SEC_W-1:0] elapsed_sec
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

    logic          lrck_prev_q;
    logic [FW-1:0] frame_q;
    logic [SEC_W-1:0] sec_q;
    logic          lrck_rise;

    assign lrck_rise   = !lrck_prev_q && lrck;
    assign elapsed_sec = sec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev_q <= 1'b0;
            frame_q     <= '0;
            sec_q       <= '0;
        end else begin
            lrck_prev_q <= lrck;
            if (clear) begin
                frame_q <= '0;
                sec_q   <= '0;
            end else if (enable && lrck_rise) begin
                if (frame_q == FRAME_LAST) begin
                    frame_q <= '0;
                    // Display value sticks at full scale rather than wrapping to zero.
                    if (sec_q != '1) begin
                        sec_q <= sec_q + 1'b1;
                    end
                end else begin
                    frame_q <= frame_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/audio_rec_play_ctrl.sv
// rtl/audio_rec_play_ctrl.sv - record/play sequencer driving the codec control levels
module audio_rec_play_ctrl #(
    parameter int FRAMES_PER_SEC = audio_pkg::DEF_FRAMES_PER_SEC,
    parameter int ADDR_W         = audio_pkg::ADDR_W,
    parameter int SEC_W          = 8
) (
    input  logic                  AUD_BCLK,
    input  logic                  rst_n,
    audio_rec_play_ctrl_if.slave  bus
);
    import audio_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_FULL = '1;

    aud_state_e        state_q, state_d;
    logic              restart_q, restart_d;
    logic [ADDR_W-1:0] rec_end_q, rec_end_d;
    logic              stop_q, record_q, interp_q, play_done_q;
    logic              fast_q, fast_d;
    logic [3:0]        rate_q, rate_d;
    logic              dac_prev_q, dac_fall;
    logic              cnt_clear, cnt_enable, active_lrck;
    logic [SEC_W-1:0]  elapsed_sec;

    assign dac_fall    = dac_prev_q && !bus.AUD_DACLRCK;
    assign active_lrck = (state_q == PLAY) ? bus.AUD_DACLRCK : bus.AUD_ADCLRCK;
    assign cnt_enable  = (state_q == RECORD) || (state_q == PLAY);
    assign cnt_clear   = ((state_d == RECORD) && (state_q != RECORD)) ||
                         ((state_d == PLAY)   && (state_q != PLAY));

    always_comb begin
        state_d   = state_q;
        restart_d = 1'b0;
        rec_end_d = rec_end_q;
        unique case (state_q)
            IDLE: begin
                if (bus.key_stop) begin
                    state_d = IDLE;
                end else if (restart_q || bus.key_record) begin
                    state_d = RECORD;
                end else if (bus.key_play && (rec_end_q != '0)) begin
                    state_d = PLAY;
                end
            end
            RECORD: begin
                if (bus.key_stop) begin
                    state_d   = IDLE;
                    rec_end_d = bus.codec_addr;
                end else if (bus.key_record) begin
                    // Pass through IDLE for one cycle so the codec sees stop and rewinds.
                    state_d   = IDLE;
                    restart_d = 1'b1;
                    rec_end_d = bus.codec_addr;
                end else if (bus.codec_addr == ADDR_FULL) begin
                    state_d   = IDLE;
                    rec_end_d = ADDR_FULL;
                end
            end
            PLAY: begin
                if (bus.key_stop) begin
                    state_d = IDLE;
                end else if (bus.key_record) begin
                    state_d = RECORD;
                end else if (bus.codec_addr >= rec_end_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Speed settings are sampled on the DAC frame boundary so a step never changes mid-frame.
    always_comb begin
        fast_d = fast_q;
        rate_d = rate_q;
        if (state_d != PLAY) begin
            fast_d = 1'b0;
        end else if (dac_fall) begin
            fast_d = bus.speed_fast;
            rate_d = (bus.speed_rate == 4'd0) ? 4'd1 : bus.speed_rate;
        end
    end

    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            restart_q   <= 1'b0;
            rec_end_q   <= '0;
            stop_q      <= 1'b1;
            record_q    <= 1'b0;
            fast_q      <= 1'b0;
            rate_q      <= 4'd1;
            interp_q    <= 1'b0;
            play_done_q <= 1'b0;
            dac_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            restart_q   <= restart_d;
            rec_end_q   <= rec_end_d;
            stop_q      <= (state_d == IDLE) || (state_d == DONE);
            record_q    <= (state_d == RECORD);
            fast_q      <= fast_d;
            rate_q      <= rate_d;
            interp_q    <= (state_d == PLAY) && bus.interp_en && !fast_d;
            play_done_q <= (state_d == DONE);
            dac_prev_q  <= bus.AUD_DACLRCK;
        end
    end

    lrck_sec_counter #(
        .FRAMES_PER_SEC (FRAMES_PER_SEC),
        .SEC_W          (SEC_W)
    ) u_sec (
        .clk         (AUD_BCLK),
        .rst_n       (rst_n),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .lrck        (active_lrck),
        .elapsed_sec (elapsed_sec)
    );

    assign bus.stop         = stop_q;
    assign bus.record       = record_q;
    assign bus.fast         = fast_q;
    assign bus.rate         = rate_q;
    assign bus.interp       = interp_q;
    assign bus.state        = state_q;
    assign bus.rec_end_addr = rec_end_q;
    assign bus.play_done    = play_done_q;
    assign bus.elapsed_sec  = elapsed_sec;

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// tb/tb_audio_rec_play_ctrl.sv - self-checking bench for audio_rec_play_ctrl
module tb_audio_rec_play_ctrl;

    localparam int AW = 18;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    audio_rec_play_ctrl_if #(.ADDR_W(AW), .SEC_W(SW)) bus ();

    audio_rec_play_ctrl #(
        .FRAMES_PER_SEC (4),
        .ADDR_W         (AW),
        .SEC_W          (SW)
    ) dut (
        .AUD_BCLK (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic          kr, kp, ks;
        logic [AW-1:0] addr;
        logic [1:0]    st;
        logic          stp, rec, pd;
    } vec_t;

    vec_t vecs[15];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic kr, input logic kp, input logic ks,
                                input logic [AW-1:0] a, input logic [1:0] st,
                                input logic stp, input logic rec, input logic pd);
        vec_t v;
        v.kr = kr; v.kp = kp; v.ks = ks; v.addr = a;
        v.st = st; v.stp = stp; v.rec = rec; v.pd = pd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_record();
        bus.key_record = 1'b1; step(); bus.key_record = 1'b0;
    endtask

    task automatic pulse_play();
        bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.key_stop = 1'b1; step(); bus.key_stop = 1'b0;
    endtask

    task automatic dac_frame();
        bus.AUD_DACLRCK = 1'b1; step();
        bus.AUD_DACLRCK = 1'b0; step();
    endtask

    // Fast play from address 0 stepping by rate; returns the address where DONE was reached.
    task automatic fast_run(input logic [3:0] r, output logic [AW-1:0] a);
        a = '0;
        for (int k = 0; k < 64; k++) begin
            a = a + AW'(r);
            bus.codec_addr = a;
            step();
            if (bus.state == 2'd3) break;
        end
    endtask

    logic [AW-1:0] done_addr;
    vec_t e;

    initial begin
        rst_n = 1'b0;
        bus.key_record = 0; bus.key_play = 0; bus.key_stop = 0;
        bus.speed_fast = 0; bus.speed_rate = 4'd0; bus.interp_en = 0;
        bus.AUD_ADCLRCK = 0; bus.AUD_DACLRCK = 0; bus.codec_addr = '0;
        step(); step();

        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_stop",   32'(bus.stop), 32'd1);
        chk("rst_record", 32'(bus.record), 32'd0);
        chk("rst_fast",   32'(bus.fast), 32'd0);
        chk("rst_rate",   32'(bus.rate), 32'd1);
        chk("rst_interp", 32'(bus.interp), 32'd0);
        chk("rst_end",    32'(bus.rec_end_addr), 32'd0);
        chk("rst_done",   32'(bus.play_done), 32'd0);
        chk("rst_sec",    32'(bus.elapsed_sec), 32'd0);
        rst_n = 1'b1;
        step();

        pulse_play();
        chk("play_no_rec", 32'(bus.state), 32'd0);

        // Record 100 frames then stop.
        pulse_record();
        chk("rec_state",  32'(bus.state), 32'd1);
        chk("rec_stop",   32'(bus.stop), 32'd0);
        chk("rec_record", 32'(bus.record), 32'd1);
        for (int i = 1; i <= 100; i++) begin
            bus.codec_addr = AW'(i);
            bus.AUD_ADCLRCK = 1'b1; step();
            bus.AUD_ADCLRCK = 1'b0; step();
        end
        chk("rec_sec_sat", 32'(bus.elapsed_sec), 32'd3);
        pulse_stop();
        chk("stop_state", 32'(bus.state), 32'd0);
        chk("stop_end",   32'(bus.rec_end_addr), 32'd100);
        chk("stop_stop",  32'(bus.stop), 32'd1);
        chk("stop_sec_hold", 32'(bus.elapsed_sec), 32'd3);

        vecs[0]  = mk(0, 1, 0, 18'd0,   2'd2, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 18'd50,  2'd2, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 18'd99,  2'd2, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 18'd100, 2'd3, 1, 0, 1);
        vecs[4]  = mk(0, 0, 0, 18'd100, 2'd0, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 18'd0,   2'd2, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 18'd10,  2'd0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 18'd0,   2'd2, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 18'd0,   2'd1, 0, 1, 0);
        vecs[9]  = mk(0, 1, 0, 18'd7,   2'd1, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 18'd5,   2'd0, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 18'd0,   2'd1, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 18'd101, 2'd0, 1, 0, 0);
        vecs[13] = mk(1, 1, 0, 18'd0,   2'd1, 0, 1, 0);
        vecs[14] = mk(0, 0, 1, 18'd101, 2'd0, 1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            bus.key_record = vecs[i].kr;
            bus.key_play   = vecs[i].kp;
            bus.key_stop   = vecs[i].ks;
            bus.codec_addr = vecs[i].addr;
            exp_q.push_back(vecs[i]);
            step();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_state", i),  32'(bus.state), 32'(e.st));
            chk($sformatf("vec%0d_stop", i),   32'(bus.stop), 32'(e.stp));
            chk($sformatf("vec%0d_record", i), 32'(bus.record), 32'(e.rec));
            chk($sformatf("vec%0d_done", i),   32'(bus.play_done), 32'(e.pd));
        end
        bus.key_record = 0; bus.key_play = 0; bus.key_stop = 0;
        chk("tbl_end", 32'(bus.rec_end_addr), 32'd101);

        // Fast play overshoot: end 101, step 4 -> DONE at 104.
        bus.speed_fast = 1'b1; bus.speed_rate = 4'd4; bus.interp_en = 1'b1;
        bus.codec_addr = '0;
        pulse_play();
        dac_frame();
        chk("fast_on",     32'(bus.fast), 32'd1);
        chk("fast_rate",   32'(bus.rate), 32'd4);
        chk("fast_interp", 32'(bus.interp), 32'd0);
        fast_run(4'd4, done_addr);
        chk("over_addr", 32'(done_addr), 32'd104);
        chk("over_pd",   32'(bus.play_done), 32'd1);
        step();
        chk("over_idle", 32'(bus.state), 32'd0);
        chk("over_pd_off", 32'(bus.play_done), 32'd0);

        bus.codec_addr = '0;
        pulse_record();
        bus.codec_addr = 18'd100;
        pulse_stop();
        chk("rerec_end", 32'(bus.rec_end_addr), 32'd100);

        // Fast play exact hit at 100.
        bus.codec_addr = '0;
        pulse_play();
        dac_frame();
        fast_run(4'd4, done_addr);
        chk("exact_addr", 32'(done_addr), 32'd100);
        chk("exact_state", 32'(bus.state), 32'd3);
        step();

        // speed_rate 0 clamps to 1.
        bus.speed_rate = 4'd0;
        bus.codec_addr = '0;
        pulse_play();
        dac_frame();
        chk("clamp_rate", 32'(bus.rate), 32'd1);
        pulse_stop();
        chk("clamp_stop", 32'(bus.state), 32'd0);

        // Normal play with interpolation and seconds counting on DACLRCK.
        bus.speed_fast = 1'b0;
        pulse_play();
        dac_frame();
        chk("norm_fast",   32'(bus.fast), 32'd0);
        chk("norm_interp", 32'(bus.interp), 32'd1);
        for (int i = 0; i < 8; i++) dac_frame();
        chk("sec_9", 32'(bus.elapsed_sec), 32'd2);
        for (int i = 0; i < 11; i++) dac_frame();
        chk("sec_sat", 32'(bus.elapsed_sec), 32'd3);
        chk("sec_play", 32'(bus.state), 32'd2);
        pulse_stop();
        chk("sec_interp_off", 32'(bus.interp), 32'd0);

        // Memory full ends recording.
        bus.codec_addr = '0;
        pulse_record();
        bus.codec_addr = audio_pkg::ADDR_MAX;
        step();
        chk("full_state", 32'(bus.state), 32'd0);
        chk("full_end",   32'(bus.rec_end_addr), 32'h3FFFF);
        chk("full_stop",  32'(bus.stop), 32'd1);
        bus.codec_addr = '0;

        // Asynchronous reset mid-record.
        pulse_record();
        chk("mid_rec", 32'(bus.state), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_end",   32'(bus.rec_end_addr), 32'd0);
        chk("arst_stop",  32'(bus.stop), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pulse_play();
        chk("arst_play_ign", 32'(bus.state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
